// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode constants: base opcodes, NOP encoding, reset vector and
// the decode-slot record handed from fetch to decode.
package fetch_stage_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b000_0011,
      OPC_OP_IMM = 7'b001_0011,
      OPC_AUIPC  = 7'b001_0111,
      OPC_STORE  = 7'b010_0011,
      OPC_OP     = 7'b011_0011,
      OPC_LUI    = 7'b011_0111,
      OPC_BRANCH = 7'b110_0011,
      OPC_JALR   = 7'b110_0111,
      OPC_JAL    = 7'b110_1111,
      OPC_SYSTEM = 7'b111_0011
   } opcode_e;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
   } id_slot_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid.sv
// Single-entry holding register with valid flag. Parks one returned
// instruction while the decode slot is still occupied.
module fetch_skid
   import fetch_stage_pkg::*;
#(
   parameter int unsigned W = XLEN
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic         i_clear,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   logic         r_valid;
   logic [W-1:0] r_data;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         // NOTE: the data register is reset as well so o_data is never X,
         // even though o_valid already qualifies it.
         r_data  <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps one request outstanding to imem and
// hands each returned word plus its PC to decode; redirects flush and restart.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_DROP} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic        r_id_valid, w_id_valid_nxt;
   id_slot_t    r_slot, w_slot_nxt;

   logic        w_skid_load, w_skid_clear, w_skid_valid;
   logic [31:0] w_skid_data;
   logic        w_slot_free, w_slot_taken;

   assign w_slot_taken = r_id_valid & id_ready;
   assign w_slot_free  = ~r_id_valid | id_ready;

   fetch_skid #(.W(32)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_skid_load),
      .i_clear (w_skid_clear),
      .i_data  (imem_rdata),
      .o_valid (w_skid_valid),
      .o_data  (w_skid_data)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statements can infer a latch.
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_slot_nxt     = r_slot;
      w_id_valid_nxt = r_id_valid & ~id_ready;
      w_skid_load    = 1'b0;
      w_skid_clear   = 1'b0;

      if (redirect_valid) begin
         w_pc_nxt       = word_align(redirect_pc);
         w_id_valid_nxt = 1'b0;
         w_skid_clear   = 1'b1;
         case (r_state)
            S_REQ:          w_state_nxt = imem_gnt ? S_DROP : S_REQ;
            S_WAIT, S_DROP: w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
            default:        w_state_nxt = S_REQ;
         endcase
      end else begin
         case (r_state)
            S_REQ: begin
               if (imem_gnt) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (w_slot_free) begin
                     w_slot_nxt.inst = imem_rdata;
                     w_slot_nxt.pc   = r_pc;
                     w_id_valid_nxt  = 1'b1;
                     w_pc_nxt        = r_pc + 32'd4;
                     w_state_nxt     = S_REQ;
                  end else begin
                     w_skid_load = 1'b1;
                     w_state_nxt = S_FULL;
                  end
               end
            end
            S_FULL: begin
               // pc still names the parked word; it advances only on delivery
               if (w_slot_taken && w_skid_valid) begin
                  w_slot_nxt.inst = w_skid_data;
                  w_slot_nxt.pc   = r_pc;
                  w_id_valid_nxt  = 1'b1;
                  w_pc_nxt        = r_pc + 32'd4;
                  w_skid_clear    = 1'b1;
                  w_state_nxt     = S_REQ;
               end
            end
            default: begin
               if (imem_rvalid) w_state_nxt = S_REQ;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_REQ;
         r_pc        <= word_align(RESET_PC);
         r_id_valid  <= 1'b0;
         r_slot.inst <= NOP_INST;
         r_slot.pc   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_id_valid <= w_id_valid_nxt;
         r_slot     <= w_slot_nxt;
      end
   end

   // Gated by rst_n so no request is visible while the block is held in reset.
   assign imem_req  = rst_n & (r_state == S_REQ);
   assign imem_addr = r_pc;

   assign id_valid = r_id_valid;
   assign id_inst  = r_slot.inst;
   assign id_pc    = r_slot.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a memory model answers grants, stimulus
// queues expected fetch addresses and deliveries, monitors pop and compare.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam int C_VALID  = 0;
   localparam int C_PEND   = 1;
   localparam int C_RVALID = 2;
   localparam int C_REQ    = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_inst;
   logic [31:0] id_pc;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_addr_q[$];
   logic [63:0] exp_inst_q[$];

   bit          rvalid_en = 1'b1;
   int          gnt_limit = 0;
   int          gnt_count;
   logic        mem_pend;
   logic [31:0] mem_addr;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_inst        (id_inst),
      .id_pc          (id_pc)
   );

   // Memory: grants when idle and under budget, answers one cycle later with
   // rdata = addr + 0x1000_0000. Reset by the same rst_n as the DUT.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_pend  <= 1'b0;
         mem_addr  <= 32'h0;
         gnt_count <= 0;
      end else begin
         if (imem_rvalid) mem_pend <= 1'b0;
         if (imem_gnt && imem_req) begin
            mem_pend  <= 1'b1;
            mem_addr  <= imem_addr;
            gnt_count <= gnt_count + 1;
         end
      end
   end

   always @(negedge clk) begin
      imem_gnt    = imem_req && !mem_pend && (gnt_count < gnt_limit);
      imem_rvalid = mem_pend && rvalid_en;
      imem_rdata  = mem_pend ? mem_addr + 32'h1000_0000 : 32'hDEAD_BEEF;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitors sample late in the low phase, when inputs for the next edge are settled.
   always @(negedge clk) begin
      #3;
      if (rst_n && imem_req && imem_gnt) begin
         if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got addr %h expected none", imem_addr);
         end else begin
            check("imem_addr", imem_addr, exp_addr_q.pop_front());
         end
      end
      if (rst_n && id_valid && id_ready) begin
         if (exp_inst_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_delivery: got pc %h inst %h expected none", id_pc, id_inst);
         end else begin
            logic [63:0] e;
            e = exp_inst_q.pop_front();
            check("id_pc", id_pc, e[63:32]);
            check("id_inst", id_inst, e[31:0]);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic bit cond_met(input int sel);
      case (sel)
         C_VALID:  return id_valid;
         C_PEND:   return mem_pend;
         C_RVALID: return imem_rvalid;
         default:  return imem_req;
      endcase
   endfunction

   task automatic wait_for(input int sel, input string name);
      int n = 0;
      while (!cond_met(sel) && n < 50) begin
         tick();
         n++;
      end
      if (!cond_met(sel)) begin
         checks++;
         errors++;
         $display("FAIL %s: got timeout expected event within 50 cycles", name);
      end
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      id_ready       = 1'b0;
      rvalid_en      = 1'b1;
      gnt_limit      = 0;
      tick();
      tick();
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_id_valid", 32'(id_valid), 32'd0);
      check("rst_id_inst", id_inst, NOP_INST);
      check("rst_id_pc", id_pc, 32'h0);
      rst_n = 1'b1;
      #1;
      check("rel_imem_req", 32'(imem_req), 32'd1);
   endtask

   task automatic drain(input string name);
      repeat (12) tick();
      check({name, "_addr_q_empty"}, 32'(exp_addr_q.size()), 32'd0);
      check({name, "_inst_q_empty"}, 32'(exp_inst_q.size()), 32'd0);
   endtask

   initial begin
      #2;

      // Streaming at best case: one instruction every other cycle.
      do_reset();
      id_ready  = 1'b1;
      gnt_limit = 3;
      exp_addr_q = '{32'h0, 32'h4, 32'h8};
      exp_inst_q = '{{32'h0, 32'h1000_0000}, {32'h4, 32'h1000_0004}, {32'h8, 32'h1000_0008}};
      wait_for(C_VALID, "t1_first");
      tick(); check("t1_gap1", 32'(id_valid), 32'd0);
      tick(); check("t1_val2", 32'(id_valid), 32'd1);
      tick(); check("t1_gap2", 32'(id_valid), 32'd0);
      tick(); check("t1_val3", 32'(id_valid), 32'd1);
      drain("t1");

      // Decode stalls: second word parks in the skid, requests stop.
      do_reset();
      gnt_limit = 3;
      exp_addr_q = '{32'h0, 32'h4, 32'h8};
      exp_inst_q = '{{32'h0, 32'h1000_0000}, {32'h4, 32'h1000_0004}, {32'h8, 32'h1000_0008}};
      wait_for(C_VALID, "t2_first");
      tick();
      tick(); check("t2_full_req", 32'(imem_req), 32'd0);
      tick(); check("t2_full_req2", 32'(imem_req), 32'd0);
      check("t2_hold_pc", id_pc, 32'h0);
      check("t2_hold_inst", id_inst, 32'h1000_0000);
      id_ready = 1'b1;
      tick();
      check("t2_skid_pc", id_pc, 32'h4);
      check("t2_skid_inst", id_inst, 32'h1000_0004);
      check("t2_next_req", 32'(imem_req), 32'd1);
      check("t2_next_addr", imem_addr, 32'h8);
      drain("t2");

      // Redirect while a request is outstanding: slot flushed, stale word dropped.
      do_reset();
      gnt_limit = 3;
      exp_addr_q = '{32'h0, 32'h4, 32'h100};
      exp_inst_q = '{{32'h100, 32'h1000_0100}};
      wait_for(C_VALID, "t3_first");
      rvalid_en = 1'b0;
      wait_for(C_PEND, "t3_wait");
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      tick();
      redirect_valid = 1'b0;
      check("t3_flush_valid", 32'(id_valid), 32'd0);
      check("t3_drop_req", 32'(imem_req), 32'd0);
      id_ready  = 1'b1;
      rvalid_en = 1'b1;
      wait_for(C_REQ, "t3_restart");
      check("t3_target", imem_addr, 32'h100);
      drain("t3");

      // Redirect in the same cycle as the response: data never reaches decode.
      do_reset();
      id_ready  = 1'b1;
      gnt_limit = 2;
      exp_addr_q = '{32'h0, 32'h200};
      exp_inst_q = '{{32'h200, 32'h1000_0200}};
      wait_for(C_RVALID, "t4_rvalid");
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      tick();
      redirect_valid = 1'b0;
      check("t4_no_valid", 32'(id_valid), 32'd0);
      check("t4_req", 32'(imem_req), 32'd1);
      check("t4_target", imem_addr, 32'h200);
      drain("t4");

      // Redirect to the top word: low bits forced to zero, PC wraps to 0.
      do_reset();
      id_ready  = 1'b1;
      gnt_limit = 3;
      exp_addr_q = '{32'h0, 32'hFFFF_FFFC, 32'h0};
      exp_inst_q = '{{32'hFFFF_FFFC, 32'h0FFF_FFFC}, {32'h0, 32'h1000_0000}};
      wait_for(C_RVALID, "t5_rvalid");
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFF;
      tick();
      redirect_valid = 1'b0;
      check("t5_target", imem_addr, 32'hFFFF_FFFC);
      drain("t5");

      // Reset mid-WAIT: outputs return to reset values at once, fetch restarts.
      do_reset();
      gnt_limit = 2;
      exp_addr_q = '{32'h0, 32'h4};
      wait_for(C_VALID, "t6_first");
      rvalid_en = 1'b0;
      wait_for(C_PEND, "t6_wait");
      rst_n = 1'b0;
      #1;
      check("t6_req", 32'(imem_req), 32'd0);
      check("t6_addr", imem_addr, 32'h0);
      check("t6_valid", 32'(id_valid), 32'd0);
      check("t6_inst", id_inst, NOP_INST);
      check("t6_pc", id_pc, 32'h0);
      tick();
      exp_addr_q.push_back(32'h0);
      exp_inst_q.push_back({32'h0, 32'h1000_0000});
      gnt_limit = 1;
      rvalid_en = 1'b1;
      id_ready  = 1'b1;
      rst_n     = 1'b1;
      drain("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
